debug_commit_sequencer: RTL and testbench
=========================================

DEBUG_COMMIT_SEQUENCER -- requirements
Module: debug_commit_sequencer

Interface
REQ-001 Parameter: DEPTH, 4, commit-record FIFO entries (power of two, 2..16).
REQ-002 clock  input  1  single clock; all state updates on posedge clock.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 in_valid  input  1  core offers a commit record.
REQ-005 in_ready  output  1  sequencer accepts the record this cycle.
REQ-006 in_halt  input  1  record is the halting instruction.
REQ-007 in_deviceAccess  input  1  record performed a device (MMIO) access.
REQ-008 in_deviceAddr  input  32  device address of the access.
REQ-009 in_pc  input  32  pc of the committed instruction.
REQ-010 intr  input  1  one-cycle interrupt-taken pulse.
REQ-011 out_valid  output  1  record presented to the simulator reporter.
REQ-012 out_ready  input  1  reporter consumes the presented record.
REQ-013 out_kind  output  2  0=COMMIT, 1=INTR, 2=HALT.
REQ-014 out_pc / out_deviceAccess / out_deviceAddr  output  32/1/32  record payload; all zero for INTR.
REQ-015 halted  output  1  HALT record delivered.
REQ-016 intr_overrun  output  1  sticky: intr received while an INTR was already pending.
REQ-017 commit_count  output  32  count of delivered COMMIT records.

Function
REQ-018 in_ready SHALL be 1 iff state==RUN and FIFO not full; a pop in the same cycle SHALL NOT free space for a push while full.
REQ-019 A record SHALL be pushed when in_valid && in_ready; a record with in_halt=1 SHALL move the state RUN->DRAIN in the same edge.
REQ-020 FIFO storage SHALL be registered; a record pushed at edge N SHALL be presentable on out_* from cycle N+1 (latency 1, throughput 1 record/cycle).
REQ-021 A record SHALL transfer when out_valid && out_ready; while out_valid && !out_ready, every out_* SHALL be held stable.
REQ-022 On an intr pulse with no INTR pending, intr_mark SHALL load the FIFO occupancy after the same-edge push and pop, so commits accepted up to and including that edge are reported first.
REQ-023 Each transferred COMMIT/HALT record SHALL decrement a nonzero intr_mark.
REQ-024 When an INTR is pending and intr_mark==0, out_* SHALL present INTR; otherwise out_* SHALL present the FIFO head; out_valid SHALL be 0 when neither exists.
REQ-025 An intr pulse while an INTR is pending SHALL be merged (one INTR reported) and SHALL set intr_overrun.
REQ-026 A FIFO head with halt=1 SHALL be presented as out_kind=HALT with its pc/device payload.
REQ-027 The HALT transfer SHALL move DRAIN->HALTED; records and intr arriving in HALTED SHALL be ignored; out_valid=0 and halted=1 in HALTED until reset.
REQ-028 The state machine SHALL have only RUN, DRAIN and HALTED; no other transitions exist.
REQ-029 commit_count SHALL increment by 1 per COMMIT transfer only (not INTR or HALT) and SHALL wrap modulo 2^32.
REQ-030 FIFO pointers SHALL wrap modulo DEPTH; occupancy SHALL span 0..DEPTH.

Reset
REQ-031 While reset==0: state=RUN, FIFO empty, no INTR pending, intr_mark=0, and in_ready, out_valid, out_kind, all payload outputs, halted, intr_overrun and commit_count all 0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered and pending records immediately (asynchronous).

Structure
REQ-033 Package debug_pkg SHALL hold the kind encoding, the state enum and the commit-record struct {halt, deviceAccess, deviceAddr, pc}.
REQ-034 The FIFO SHALL be one sub-module, debug_fifo, parameterised by DEPTH and the record width.

Verification
REQ-035 Stream: out_ready=1; push pc 0x80000000, 0x80000004, 0x80000008 on consecutive cycles -> three COMMIT records in the same order, each one cycle after its push; commit_count=3.
REQ-036 Backpressure: DEPTH=4, out_ready=0; push 5 records -> in_ready drops after the 4th; out_* stays on pc of record 1 until out_ready=1.
REQ-037 Intr ordering: 2 records queued, intr pulses with a 3rd push on the same edge -> order COMMIT, COMMIT, COMMIT, INTR; a second intr before the INTR is delivered -> intr_overrun=1, single INTR.
REQ-038 Halt: push pc 0x80000010 with halt=1, then attempt a push -> in_ready=0; HALT record with pc 0x80000010; halted=1 next cycle; later in_valid/intr are ignored.
REQ-039 Reset: assert reset with 3 records queued and an INTR pending -> all outputs 0 asynchronously; after release out_valid=0 and in_ready=1.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared types for the debug commit sequencer: report kinds, sequencer states
// and the commit record carried through the FIFO.
package debug_pkg;

  typedef enum logic [1:0] {
    KIND_COMMIT = 2'd0,
    KIND_INTR   = 2'd1,
    KIND_HALT   = 2'd2
  } kind_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_HALTED  = 2'd2
  } state_e;

  typedef struct packed {
    logic        halt;
    logic        deviceAccess;
    logic [31:0] deviceAddr;
    logic [31:0] pc;
  } commit_rec_t;

  localparam int REC_W = $bits(commit_rec_t);

endpackage

// File: rtl/debug_fifo.sv
// Registered-storage FIFO for commit records; head is readable the cycle after
// a push. Pointers wrap naturally because DEPTH is a power of two.
module debug_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/debug_commit_sequencer.sv
// Orders commit records, interrupt markers and the final halt record into a
// single stream for the simulator reporter.
module debug_commit_sequencer
  import debug_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_halt,
  input  logic        in_deviceAccess,
  input  logic [31:0] in_deviceAddr,
  input  logic [31:0] in_pc,
  input  logic        intr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_kind,
  output logic [31:0] out_pc,
  output logic        out_deviceAccess,
  output logic [31:0] out_deviceAddr,
  output logic        halted,
  output logic        intr_overrun,
  output logic [31:0] commit_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e      state;
  commit_rec_t push_rec;
  commit_rec_t head;
  logic [CW-1:0] count;
  logic [CW-1:0] occ_next;
  logic [CW-1:0] intr_mark;
  logic        full;
  logic        empty;
  logic        intr_pending;
  logic        push;
  logic        pop;
  logic        present_intr;
  logic        xfer;
  logic        intr_xfer;

  assign push_rec = '{halt: in_halt, deviceAccess: in_deviceAccess,
                      deviceAddr: in_deviceAddr, pc: in_pc};

  debug_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // in_ready is gated by reset so it reads 0 while reset is held.
  assign in_ready     = reset && (state == ST_RUN) && !full;
  assign push         = in_valid && in_ready;
  assign present_intr = intr_pending && (intr_mark == '0);
  assign out_valid    = (state != ST_HALTED) && (present_intr || !empty);
  assign xfer         = out_valid && out_ready;
  assign pop          = xfer && !present_intr;
  assign intr_xfer    = xfer && present_intr;
  assign occ_next     = count + CW'(push) - CW'(pop);
  assign halted       = (state == ST_HALTED);

  always_comb begin
    out_kind         = KIND_COMMIT;
    out_pc           = '0;
    out_deviceAccess = 1'b0;
    out_deviceAddr   = '0;
    if (out_valid && present_intr) begin
      out_kind = KIND_INTR;
    end else if (out_valid) begin
      out_kind         = head.halt ? KIND_HALT : KIND_COMMIT;
      out_pc           = head.pc;
      out_deviceAccess = head.deviceAccess;
      out_deviceAddr   = head.deviceAddr;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_RUN;
      intr_pending <= 1'b0;
      intr_mark    <= '0;
      intr_overrun <= 1'b0;
      commit_count <= '0;
    end else begin
      case (state)
        ST_RUN:   if (push && in_halt) state <= ST_DRAIN;
        ST_DRAIN: if (pop && head.halt) state <= ST_HALTED;
        default:  ;
      endcase
      if (pop && !head.halt) commit_count <= commit_count + 32'd1;
      if (pop && intr_mark != '0) intr_mark <= intr_mark - CW'(1);
      if (intr_xfer) intr_pending <= 1'b0;
      // An INTR leaving this edge frees the slot, so a same-edge pulse starts fresh.
      if (intr && state != ST_HALTED) begin
        if (intr_pending && !intr_xfer) begin
          intr_overrun <= 1'b1;
        end else begin
          intr_pending <= 1'b1;
          intr_mark    <= occ_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_debug_commit_sequencer.sv
// Directed bench for debug_commit_sequencer: a per-cycle vector table for
// streaming and interrupt ordering, plus sequences for backpressure, halt and reset.
module tb_debug_commit_sequencer;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_halt;
  logic        in_deviceAccess;
  logic [31:0] in_deviceAddr;
  logic [31:0] in_pc;
  logic        intr;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_kind;
  logic [31:0] out_pc;
  logic        out_deviceAccess;
  logic [31:0] out_deviceAddr;
  logic        halted;
  logic        intr_overrun;
  logic [31:0] commit_count;

  int tests;
  int fails;

  debug_commit_sequencer #(.DEPTH(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_halt          (in_halt),
    .in_deviceAccess  (in_deviceAccess),
    .in_deviceAddr    (in_deviceAddr),
    .in_pc            (in_pc),
    .intr             (intr),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_kind         (out_kind),
    .out_pc           (out_pc),
    .out_deviceAccess (out_deviceAccess),
    .out_deviceAddr   (out_deviceAddr),
    .halted           (halted),
    .intr_overrun     (intr_overrun),
    .commit_count     (commit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        vld;
    logic        dev;
    logic [31:0] addr;
    logic [31:0] pc;
    logic        irq;
    logic        ordy;
    logic        e_irdy;
    logic        e_ovld;
    logic [1:0]  e_kind;
    logic [31:0] e_pc;
    logic        e_dev;
    logic [31:0] e_addr;
    logic        e_ovr;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(logic vld, logic dev, logic [31:0] addr, logic [31:0] pc,
                              logic irq, logic ordy, logic e_irdy, logic e_ovld,
                              logic [1:0] e_kind, logic [31:0] e_pc, logic e_dev,
                              logic [31:0] e_addr, logic e_ovr, logic [31:0] e_cnt);
    vec_t v;
    v.vld = vld; v.dev = dev; v.addr = addr; v.pc = pc; v.irq = irq; v.ordy = ordy;
    v.e_irdy = e_irdy; v.e_ovld = e_ovld; v.e_kind = e_kind; v.e_pc = e_pc;
    v.e_dev = e_dev; v.e_addr = e_addr; v.e_ovr = e_ovr; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " out_kind"}, 32'(out_kind), 32'd0);
    chk({tag, " out_pc"}, out_pc, 32'd0);
    chk({tag, " out_deviceAccess"}, 32'(out_deviceAccess), 32'd0);
    chk({tag, " out_deviceAddr"}, out_deviceAddr, 32'd0);
    chk({tag, " halted"}, 32'(halted), 32'd0);
    chk({tag, " intr_overrun"}, 32'(intr_overrun), 32'd0);
    chk({tag, " commit_count"}, commit_count, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    in_valid = 1'b0; in_halt = 1'b0; in_deviceAccess = 1'b0;
    in_deviceAddr = '0; in_pc = '0; intr = 1'b0; out_ready = 1'b0;

    // Stream of three commits, then interrupt ordering with a merged second pulse.
    vecs[0]  = mk(1, 0, 32'h0,        32'h80000000, 0, 1,  1, 0, 2'd0, 32'h0,        0, 32'h0,        0, 0);
    vecs[1]  = mk(1, 1, 32'h10000000, 32'h80000004, 0, 1,  1, 1, 2'd0, 32'h80000000, 0, 32'h0,        0, 0);
    vecs[2]  = mk(1, 0, 32'h0,        32'h80000008, 0, 1,  1, 1, 2'd0, 32'h80000004, 1, 32'h10000000, 0, 1);
    vecs[3]  = mk(0, 0, 32'h0,        32'h0,        0, 1,  1, 1, 2'd0, 32'h80000008, 0, 32'h0,        0, 2);
    vecs[4]  = mk(0, 0, 32'h0,        32'h0,        0, 1,  1, 0, 2'd0, 32'h0,        0, 32'h0,        0, 3);
    vecs[5]  = mk(1, 0, 32'h0,        32'h100,      0, 0,  1, 0, 2'd0, 32'h0,        0, 32'h0,        0, 3);
    vecs[6]  = mk(1, 0, 32'h0,        32'h104,      0, 0,  1, 1, 2'd0, 32'h100,      0, 32'h0,        0, 3);
    vecs[7]  = mk(1, 0, 32'h0,        32'h108,      1, 0,  1, 1, 2'd0, 32'h100,      0, 32'h0,        0, 3);
    vecs[8]  = mk(0, 0, 32'h0,        32'h0,        1, 1,  1, 1, 2'd0, 32'h100,      0, 32'h0,        0, 3);
    vecs[9]  = mk(0, 0, 32'h0,        32'h0,        0, 1,  1, 1, 2'd0, 32'h104,      0, 32'h0,        1, 4);
    vecs[10] = mk(0, 0, 32'h0,        32'h0,        0, 1,  1, 1, 2'd0, 32'h108,      0, 32'h0,        1, 5);
    vecs[11] = mk(0, 0, 32'h0,        32'h0,        0, 1,  1, 1, 2'd1, 32'h0,        0, 32'h0,        1, 6);
    vecs[12] = mk(0, 0, 32'h0,        32'h0,        0, 1,  1, 0, 2'd0, 32'h0,        0, 32'h0,        1, 6);

    #3;
    chk_all_zero("reset_hold");
    next_cycle();
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      in_valid = vecs[i].vld; in_deviceAccess = vecs[i].dev; in_deviceAddr = vecs[i].addr;
      in_pc = vecs[i].pc; intr = vecs[i].irq; out_ready = vecs[i].ordy; in_halt = 1'b0;
      @(negedge clock);
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_irdy));
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ovld));
      chk($sformatf("vec%0d out_kind", i), 32'(out_kind), 32'(vecs[i].e_kind));
      chk($sformatf("vec%0d out_pc", i), out_pc, vecs[i].e_pc);
      chk($sformatf("vec%0d out_deviceAccess", i), 32'(out_deviceAccess), 32'(vecs[i].e_dev));
      chk($sformatf("vec%0d out_deviceAddr", i), out_deviceAddr, vecs[i].e_addr);
      chk($sformatf("vec%0d intr_overrun", i), 32'(intr_overrun), 32'(vecs[i].e_ovr));
      chk($sformatf("vec%0d commit_count", i), commit_count, vecs[i].e_cnt);
      next_cycle();
    end
    in_valid = 1'b0; intr = 1'b0; in_deviceAccess = 1'b0; in_deviceAddr = '0;

    // Backpressure: five offers into a four-entry FIFO with the reporter stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_pc = 32'h200 + 32'(4 * i);
      @(negedge clock);
      chk($sformatf("bp push%0d in_ready", i), 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
      if (i > 0) chk($sformatf("bp push%0d out_pc", i), out_pc, 32'h200);
      next_cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("bp hold%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp hold%0d out_pc", i), out_pc, 32'h200);
      next_cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk($sformatf("bp drain%0d out_pc", i), out_pc, 32'h200 + 32'(4 * i));
      next_cycle();
    end
    @(negedge clock);
    chk("bp drained out_valid", 32'(out_valid), 32'd0);
    chk("bp drained commit_count", commit_count, 32'd10);
    next_cycle();

    // Halt record, blocked follow-up push, then HALTED ignores everything.
    out_ready = 1'b0;
    in_valid = 1'b1; in_halt = 1'b1; in_pc = 32'h80000010;
    @(negedge clock);
    chk("halt push in_ready", 32'(in_ready), 32'd1);
    next_cycle();
    in_halt = 1'b0; in_pc = 32'h80000014;
    @(negedge clock);
    chk("halt drain in_ready", 32'(in_ready), 32'd0);
    chk("halt out_valid", 32'(out_valid), 32'd1);
    chk("halt out_kind", 32'(out_kind), 32'd2);
    chk("halt out_pc", out_pc, 32'h80000010);
    chk("halt halted early", 32'(halted), 32'd0);
    next_cycle();
    out_ready = 1'b1;
    next_cycle();
    intr = 1'b1;
    @(negedge clock);
    chk("halted halted", 32'(halted), 32'd1);
    chk("halted out_valid", 32'(out_valid), 32'd0);
    chk("halted in_ready", 32'(in_ready), 32'd0);
    next_cycle();
    intr = 1'b0;
    @(negedge clock);
    chk("halted ignore out_valid", 32'(out_valid), 32'd0);
    chk("halted commit_count", commit_count, 32'd10);
    next_cycle();
    in_valid = 1'b0;

    // Reset leaves HALTED, then an asynchronous reset discards queued records and a pending INTR.
    reset = 1'b0;
    #2;
    chk("reset pulse halted", 32'(halted), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("post reset in_ready", 32'(in_ready), 32'd1);
    chk("post reset commit_count", commit_count, 32'd0);
    next_cycle();
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h300;
    next_cycle();
    in_pc = 32'h304;
    next_cycle();
    out_ready = 1'b0; in_pc = 32'h308;
    next_cycle();
    in_pc = 32'h30C; intr = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    intr = 1'b0;
    @(negedge clock);
    chk("pre reset commit_count", commit_count, 32'd1);
    chk("pre reset intr_overrun", 32'(intr_overrun), 32'd1);
    chk("pre reset out_pc", out_pc, 32'h304);
    #1;
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    #1;
    reset = 1'b1;
    @(negedge clock);
    chk("release out_valid", 32'(out_valid), 32'd0);
    chk("release in_ready", 32'(in_ready), 32'd1);
    next_cycle();
    @(negedge clock);
    chk("release no intr out_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
